// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types and constants for the padder and hash core
package sha256_pkg;
  typedef enum logic [1:0] {FILL, PAD, TAIL, EMIT} state_e;
  typedef enum logic [2:0] {BUF_HOLD, BUF_WR, BUF_PAD, BUF_PAD_LEN, BUF_TAIL, BUF_CLR} buf_op_e;
  localparam int BLK_BYTES = 64;
  localparam int LEN_OFFSET = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic logic len_fits(input logic [6:0] idx);
    return idx < 7'(LEN_OFFSET);
  endfunction
endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: byte-in / block-out handshake bundle; in_flush exists only with SHA_PAD_EMPTY_MSG_EN
interface sha256_msg_padder_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [511:0] blk_data;
  logic blk_valid;
  logic blk_first;
  logic blk_last;
  logic blk_ready;
`ifdef SHA_PAD_EMPTY_MSG_EN
  logic in_flush;
`endif
  modport master (
    output in_data, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
`ifdef SHA_PAD_EMPTY_MSG_EN
    , output in_flush
`endif
  );
  modport slave (
    input  in_data, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last
`ifdef SHA_PAD_EMPTY_MSG_EN
    , input in_flush
`endif
  );
endinterface

// File: rtl/sha256_blk_buf.sv
// sha256_blk_buf: 64-byte block register file with byte write, pad-fill, length insert and clear
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  buf_op_e      op_i,
  input  logic [5:0]   idx_i,
  input  logic [7:0]   din_i,
  input  logic [63:0]  len_i,
  output logic [511:0] data_o
);
  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_byte
    logic [7:0] len_b, pad_b, byte_d, byte_q;
    if (g >= LEN_OFFSET) begin : g_len
      assign len_b = len_i[8*(BLK_BYTES-1-g) +: 8];
    end else begin : g_nolen
      assign len_b = 8'h00;
    end
    // next byte value: keep bytes before idx, 0x80 at idx, then zeros or the length field
    always_comb begin
      pad_b = 6'(g) < idx_i ? byte_q : 6'(g) == idx_i ? PAD_BYTE : op_i == BUF_PAD_LEN ? len_b : 8'h00;
      byte_d = op_i == BUF_WR ? (6'(g) == idx_i ? din_i : byte_q) :
               (op_i == BUF_PAD || op_i == BUF_PAD_LEN) ? pad_b :
               op_i == BUF_TAIL ? len_b :
               op_i == BUF_CLR ? 8'h00 : byte_q;
    end
    // byte storage, cleared by reset
    always_ff @(posedge clk or negedge rst)
      if (!rst) byte_q <= 8'h00;
      else byte_q <= byte_d;
    assign data_o[8*(BLK_BYTES-g)-1 -: 8] = byte_q;
  end
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: SHA-256 message padder, byte stream in, 512-bit blocks out; SHA_PAD_EMPTY_MSG_EN adds in_flush for empty messages
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input logic clk,
  input logic rst,
  sha256_msg_padder_if.slave bus
);
  state_e state_q;
  logic [6:0] idx_q;
  logic [LEN_W-1:0] cnt_q;
  logic first_q, pad_pend_q, tail_pend_q;
  logic in_ready_q, blk_valid_q, blk_first_q, blk_last_q;
  logic accept, flush_go;
  logic [6:0] idx_inc;
  logic [63:0] bit_len;
  buf_op_e buf_op;
  assign accept = bus.in_valid & in_ready_q;
  assign idx_inc = idx_q + 7'd1;
  assign bit_len = 64'({cnt_q, 3'b000});
`ifdef SHA_PAD_EMPTY_MSG_EN
  assign flush_go = bus.in_flush && state_q == FILL && idx_q == 7'd0 && cnt_q == '0;
`else
  assign flush_go = 1'b0;
`endif
  // buffer operation selected by the current state
  always_comb begin
    buf_op = BUF_HOLD;
    case (state_q)
      FILL: if (accept) buf_op = BUF_WR;
      PAD: buf_op = len_fits(idx_q) ? BUF_PAD_LEN : BUF_PAD;
      TAIL: buf_op = BUF_TAIL;
      EMIT: if (bus.blk_ready) buf_op = BUF_CLR;
      default: buf_op = BUF_HOLD;
    endcase
  end
  sha256_blk_buf u_buf (
    .clk(clk),
    .rst(rst),
    .op_i(buf_op),
    .idx_i(idx_q[5:0]),
    .din_i(bus.in_data),
    .len_i(bit_len),
    .data_o(bus.blk_data)
  );
  // control FSM: fill bytes, pad, optional length-only tail block, hold block until accepted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FILL;
      idx_q <= 7'd0;
      cnt_q <= '0;
      first_q <= 1'b1;
      pad_pend_q <= 1'b0;
      tail_pend_q <= 1'b0;
      in_ready_q <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q <= 1'b0;
    end else begin
      case (state_q)
        FILL:
          if (accept) begin
            idx_q <= idx_inc;
            cnt_q <= cnt_q + LEN_W'(1);
            if (idx_inc[6] || bus.in_last) in_ready_q <= 1'b0;
            if (idx_inc[6]) begin
              state_q <= EMIT;
              blk_valid_q <= 1'b1;
              blk_first_q <= first_q;
              blk_last_q <= 1'b0;
              pad_pend_q <= bus.in_last;
            end else if (bus.in_last) state_q <= PAD;
          end else if (flush_go) begin
            state_q <= PAD;
            in_ready_q <= 1'b0;
          end
        PAD: begin
          state_q <= EMIT;
          blk_valid_q <= 1'b1;
          blk_first_q <= first_q;
          blk_last_q <= len_fits(idx_q);
          tail_pend_q <= !len_fits(idx_q);
        end
        TAIL: begin
          state_q <= EMIT;
          blk_valid_q <= 1'b1;
          blk_first_q <= first_q;
          blk_last_q <= 1'b1;
        end
        EMIT:
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q <= 1'b0;
            idx_q <= 7'd0;
            first_q <= 1'b0;
            if (pad_pend_q) begin
              pad_pend_q <= 1'b0;
              state_q <= PAD;
            end else if (tail_pend_q) begin
              tail_pend_q <= 1'b0;
              state_q <= TAIL;
            end else begin
              state_q <= FILL;
              in_ready_q <= 1'b1;
              if (blk_last_q) begin
                cnt_q <= '0;
                first_q <= 1'b1;
              end
            end
          end
        default: state_q <= FILL;
      endcase
    end
  assign bus.in_ready = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last = blk_last_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed scoreboard bench for the SHA-256 padder
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sha256_msg_padder_if bus();
  sha256_msg_padder dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [511:0] data;
    logic first;
    logic last;
  } blk_t;
  blk_t exp_q[$];
  blk_t got;
  logic [7:0] msg[$];
  int tests = 0;
  int fails = 0;
  logic [511:0] abc_blk;
  logic [511:0] prev_data;
  logic prev_first, prev_last;
  bit prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_expected();
    logic [7:0] p[$];
    logic [63:0] bl;
    blk_t e;
    int n;
    p = msg;
    bl = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    n = p.size() / 64;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 64; i++) e.data[511-8*i -: 8] = p[64*b+i];
      e.first = (b == 0);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_msg(input bit with_last);
    int n;
    for (int i = 0; i < msg.size(); i++) begin
      bus.in_data = msg[i];
      bus.in_valid = 1'b1;
      bus.in_last = with_last && (i == msg.size() - 1);
      n = 0;
      while (!bus.in_ready && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 300) begin
        tests++;
        fails++;
        $error("FAIL in_ready_timeout: observed 0 expected 1");
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.blk_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic rand_msg(input int len);
    msg = {};
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  always @(negedge clk) begin
    if (!rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 512'(bus.blk_valid), 512'(1));
        chk("hold_data", bus.blk_data, prev_data);
        chk("hold_first", 512'(bus.blk_first), 512'(prev_first));
        chk("hold_last", 512'(bus.blk_last), 512'(prev_last));
      end
      if (bus.blk_valid) chk("in_ready_emit", 512'(bus.in_ready), 512'(0));
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_block: observed %h expected none", bus.blk_data);
        end else begin
          got = exp_q.pop_front();
          chk("blk_data", bus.blk_data, got.data);
          chk("blk_first", 512'(bus.blk_first), 512'(got.first));
          chk("blk_last", 512'(bus.blk_last), 512'(got.last));
        end
      end
      prev_stall = bus.blk_valid && !bus.blk_ready;
      prev_data = bus.blk_data;
      prev_first = bus.blk_first;
      prev_last = bus.blk_last;
    end
  end

  initial begin
    int n;
    abc_blk = {32'h61626380, 416'h0, 64'h18};
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.blk_ready = 1'b0;
`ifdef SHA_PAD_EMPTY_MSG_EN
    bus.in_flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    chk("rst_blk_first", 512'(bus.blk_first), 512'(0));
    chk("rst_blk_last", 512'(bus.blk_last), 512'(0));
    chk("rst_blk_data", bus.blk_data, 512'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    bus.blk_ready = 1'b1;
    // "abc": one block, two-cycle latency from last byte
    msg = {8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(1'b1);
    chk("abc_lat_pad", 512'(bus.blk_valid), 512'(0));
    @(posedge clk); #1;
    chk("abc_lat_emit", 512'(bus.blk_valid), 512'(1));
    chk("abc_const_data", bus.blk_data, abc_blk);
    chk("abc_const_first", 512'(bus.blk_first), 512'(1));
    chk("abc_const_last", 512'(bus.blk_last), 512'(1));
    drain();
    // 55 zero bytes: length still fits
    msg = {};
    repeat (55) msg.push_back(8'h00);
    push_expected();
    send_msg(1'b1);
    drain();
    // 56 bytes: pad block then length-only tail block
    rand_msg(56);
    push_expected();
    send_msg(1'b1);
    drain();
    // 64 bytes: full block right after the 64th byte, then pad block
    rand_msg(64);
    push_expected();
    send_msg(1'b1);
    chk("full_blk_latency", 512'(bus.blk_valid), 512'(1));
    chk("full_blk_last", 512'(bus.blk_last), 512'(0));
    drain();
    // 130 bytes: three blocks
    rand_msg(130);
    push_expected();
    send_msg(1'b1);
    drain();
    // backpressure: hold blk_ready low for 5 cycles in EMIT
    bus.blk_ready = 1'b0;
    rand_msg(10);
    push_expected();
    send_msg(1'b1);
    n = 0;
    while (!bus.blk_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 512'(bus.blk_valid), 512'(1));
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_held", 512'(bus.blk_valid), 512'(1));
    chk("bp_in_ready_low", 512'(bus.in_ready), 512'(0));
    bus.blk_ready = 1'b1;
    drain();
    msg = {8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(1'b1);
    drain();
    // reset mid-message discards the partial message
    rand_msg(10);
    send_msg(1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 512'(bus.blk_valid), 512'(0));
    chk("mid_rst_in_ready", 512'(bus.in_ready), 512'(1));
    msg = {8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(1'b1);
    @(posedge clk); #1;
    chk("post_rst_abc_data", bus.blk_data, abc_blk);
    drain();
`ifdef SHA_PAD_EMPTY_MSG_EN
    // empty message via flush
    msg = {};
    push_expected();
    bus.in_flush = 1'b1;
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    drain();
    // flush mid-message is ignored
    msg = {8'h61, 8'h62, 8'h63};
    push_expected();
    msg = {8'h61, 8'h62};
    send_msg(1'b0);
    bus.in_flush = 1'b1;
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("flush_ignored", 512'(bus.blk_valid), 512'(0));
    msg = {8'h63};
    send_msg(1'b1);
    drain();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
